pixel_downscaler: RTL and testbench

PIXEL_DOWNSCALER -- requirements
Module: pixel_downscaler

---
 rtl/pixel_downscaler.sv | 146 ++++++++++++++
 tb/tb_pixel_downscaler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_downscaler.sv
// pixel_downscaler: 2:1 downscale of a FIFO-fed pixel stream,
// either top-left decimation or 2x2 box average per channel.
module pixel_downscaler #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int NCH   = 3,
  parameter int CH_W  = 4,
  localparam int PIX_W = NCH * CH_W,
  localparam int OXW   = $clog2(IMG_W / 2),
  localparam int OYW   = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             href_in,
  input  logic             vsync_in,
  input  logic             mode,
  output logic [PIX_W-1:0] scaled_data,
  output logic             scaled_valid,
  output logic [OXW-1:0]   o_x_count,
  output logic [OYW-1:0]   o_y_count
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW  = CH_W + 1;
  localparam int SW  = CH_W + 2;
  localparam int LBW = NCH * HW;
  localparam int LBN = IMG_W / 2;

  logic             rd_d1;
  logic             href_q1, href_q2;
  logic             vs_q1, vs_q2;
  logic             active_mode;
  logic             synced;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [PIX_W-1:0] h_reg;
  logic [LBN-1:0]   lb_vld;
  logic [LBW-1:0]   lbuf [LBN];
  logic [LBW-1:0]   lb_rd;
  logic [LBW-1:0]   hsum;
  logic [PIX_W-1:0] avg;
  logic [HW-1:0]    hs;
  logic [SW-1:0]    tot;
  logic [OXW-1:0]   xh;

  logic href_fall, vs_rise, acc;
  logic x_last, y_last;
  logic dec_hit, avg_hit;

  assign href_fall = href_q2 & ~href_q1;
  assign vs_rise   = vs_q1 & ~vs_q2;
  assign acc       = rd_d1 & ~href_fall & ~vs_rise;
  assign x_last    = (x == XW'(IMG_W - 1));
  assign y_last    = (y == YW'(IMG_H - 1));
  assign xh        = OXW'(x >> 1);
  assign lb_rd     = lbuf[xh];

  assign dec_hit = acc & synced & ~active_mode
                 & ~x[0] & ~y[0];
  assign avg_hit = acc & synced & active_mode
                 & x[0] & y[0] & lb_vld[xh];

  always_comb begin
    hs   = '0;
    tot  = '0;
    hsum = '0;
    avg  = '0;
    for (int k = 0; k < NCH; k++) begin
      hs  = HW'(h_reg[k*CH_W +: CH_W])
          + HW'(fifo_dout[k*CH_W +: CH_W]);
      tot = SW'(hs) + SW'(lb_rd[k*HW +: HW]);
      hsum[k*HW +: HW]    = hs;
      avg[k*CH_W +: CH_W] = tot[SW-1:2];
    end
  end

  // even rows park their horizontal pair sums for the odd row
  always_ff @(posedge clk) begin
    if (acc && x[0] && !y[0])
      lbuf[xh] <= hsum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rd_en   <= 1'b0;
      rd_d1        <= 1'b0;
      href_q1      <= 1'b0;
      href_q2      <= 1'b0;
      vs_q1        <= 1'b0;
      vs_q2        <= 1'b0;
      active_mode  <= mode;
      synced       <= 1'b0;
      x            <= '0;
      y            <= '0;
      h_reg        <= '0;
      lb_vld       <= '0;
      scaled_valid <= 1'b0;
      scaled_data  <= '0;
      o_x_count    <= '0;
      o_y_count    <= '0;
    end else begin
      fifo_rd_en   <= ~fifo_empty;
      rd_d1        <= fifo_rd_en;
      href_q1      <= href_in;
      href_q2      <= href_q1;
      vs_q1        <= vsync_in;
      vs_q2        <= vs_q1;
      scaled_valid <= dec_hit | avg_hit;
      if (dec_hit || avg_hit) begin
        scaled_data <= avg_hit ? avg : fifo_dout;
        o_x_count   <= xh;
        o_y_count   <= OYW'(y >> 1);
      end
      if (vs_rise) begin
        x           <= '0;
        y           <= '0;
        lb_vld      <= '0;
        active_mode <= mode;
        synced      <= 1'b1;
      end else if (href_fall) begin
        x <= '0;
      end else if (rd_d1) begin
        if (!x[0])
          h_reg <= fifo_dout;
        else if (!y[0])
          lb_vld[xh] <= 1'b1;
        if (x_last) begin
          x <= '0;
          if (y_last) begin
            y      <= '0;
            synced <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_downscaler.sv
// tb_pixel_downscaler: scoreboard bench for the 2:1 pixel downscaler
// on a small 8x4 image with a modelled standard FIFO.
module tb_pixel_downscaler;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int OXW = 2;
  localparam int OYW = 1;

  logic            clk = 0;
  logic            rst;
  logic [11:0]     fifo_dout;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic            href_in;
  logic            vsync_in;
  logic            mode;
  logic [11:0]     scaled_data;
  logic            scaled_valid;
  logic [OXW-1:0]  o_x_count;
  logic [OYW-1:0]  o_y_count;

  pixel_downscaler #(
    .IMG_W(W), .IMG_H(H), .NCH(3), .CH_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .href_in(href_in), .vsync_in(vsync_in), .mode(mode),
    .scaled_data(scaled_data), .scaled_valid(scaled_valid),
    .o_x_count(o_x_count), .o_y_count(o_y_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    int          ox;
    int          oy;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] src_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_out  = 0;
  bit          stall_en = 0;
  bit          auto_exp = 1;

  int          mx, my;
  bit          msync, mmode;
  logic [11:0] mh;
  logic [11:0] mtop0 [W/2];
  logic [11:0] mtop1 [W/2];
  bit          mlbv  [W/2];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic logic [11:0] avg4(input logic [11:0] a,
      input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
    logic [11:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = int'(a[k*4 +: 4]) + int'(b[k*4 +: 4])
        + int'(c[k*4 +: 4]) + int'(d[k*4 +: 4]);
      s = s / 4;
      r[k*4 +: 4] = 4'(s);
    end
    return r;
  endfunction

  task automatic push_exp(input logic [11:0] d, input int ox, input int oy);
    exp_t e;
    e.d = d; e.ox = ox; e.oy = oy;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; msync = 0; mmode = mode;
    for (int i = 0; i < W/2; i++) mlbv[i] = 0;
  endtask

  task automatic model_vsync();
    mx = 0; my = 0; msync = 1; mmode = mode;
    for (int i = 0; i < W/2; i++) mlbv[i] = 0;
  endtask

  task automatic model_pix(input logic [11:0] p);
    int b;
    b = mx / 2;
    if (auto_exp && msync && !mmode && mx % 2 == 0 && my % 2 == 0)
      push_exp(p, b, my / 2);
    if (auto_exp && msync && mmode && mx % 2 == 1 && my % 2 == 1 && mlbv[b])
      push_exp(avg4(mtop0[b], mtop1[b], mh, p), b, my / 2);
    if (mx % 2 == 0) mh = p;
    if (my % 2 == 0) begin
      if (mx % 2 == 0) mtop0[b] = p;
      else begin mtop1[b] = p; mlbv[b] = 1; end
    end
    if (mx == W - 1) begin
      mx = 0;
      if (my == H - 1) begin my = 0; msync = 1; end
      else my++;
    end else mx++;
  endtask

  task automatic feed(input logic [11:0] p);
    src_q.push_back(p);
    model_pix(p);
  endtask

  function automatic logic [11:0] gen(input int kind, input int x, input int y);
    case (kind)
      0:       return 12'(x + y);
      1:       return 12'(x * 37 + y * 101 + 5);
      default: return 12'(x * 53 + y * 29 + 7);
    endcase
  endfunction

  task automatic feed_rows(input int kind, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = 0; xx < W; xx++)
        feed(gen(kind, xx, yy));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((src_q.size() != 0 || fifo_rd_en) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: queue=%0d", src_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_vsync();
    @(negedge clk); vsync_in = 1;
    repeat (3) @(negedge clk);
    vsync_in = 0;
    repeat (4) @(negedge clk);
    model_vsync();
  endtask

  task automatic pulse_href();
    @(negedge clk); href_in = 0;
    repeat (2) @(negedge clk);
    href_in = 1;
    repeat (4) @(negedge clk);
    mx = 0;
  endtask

  // standard FIFO: data appears one cycle after the read request
  initial begin
    bit pop;
    fifo_empty = 1;
    fifo_dout  = '0;
    forever begin
      @(negedge clk);
      pop = fifo_rd_en && !rst;
      fifo_empty = (stall_en && $urandom_range(99) < 30) ||
                   (int'(src_q.size()) - int'(pop) <= 0);
      @(posedge clk); #1;
      if (pop && src_q.size() != 0) fifo_dout = src_q.pop_front();
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && fifo_empty) begin
        n_chk++;
        if (fifo_rd_en) begin
          n_fail++;
          $display("FAIL rd_after_empty: rd_en=1 at t=%0t", $time);
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic [11:0] ld;
    int lx, ly;
    ld = '0; lx = 0; ly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ld = '0; lx = 0; ly = 0;
      end else if (scaled_valid) begin
        n_out++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: data=%h x=%0d y=%0d",
                   scaled_data, o_x_count, o_y_count);
        end else begin
          e = exp_q.pop_front();
          if (scaled_data !== e.d || int'(o_x_count) != e.ox ||
              int'(o_y_count) != e.oy) begin
            n_fail++;
            $display("FAIL out: got %h (%0d,%0d) expected %h (%0d,%0d)",
                     scaled_data, o_x_count, o_y_count, e.d, e.ox, e.oy);
          end
        end
        ld = scaled_data; lx = int'(o_x_count); ly = int'(o_y_count);
      end else begin
        n_chk++;
        if (scaled_data !== ld || int'(o_x_count) != lx ||
            int'(o_y_count) != ly) begin
          n_fail++;
          $display("FAIL hold: got %h (%0d,%0d) expected %h (%0d,%0d)",
                   scaled_data, o_x_count, o_y_count, ld, lx, ly);
        end
      end
    end
  end

  initial begin
    int n0;
    logic [11:0] p;
    rst = 1; mode = 0; href_in = 1; vsync_in = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(scaled_valid), 0);
    chk("rst_data", int'(scaled_data), 0);
    chk("rst_ox", int'(o_x_count), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    rst = 0;
    repeat (2) @(negedge clk);

    pulse_vsync();
    n0 = n_out;
    feed_rows(0, 0, H - 1);
    drain();
    chk("dec_count", n_out - n0, W * H / 4);

    stall_en = 1;
    n0 = n_out;
    feed_rows(0, 0, H - 1);
    drain();
    stall_en = 0;
    chk("stall_count", n_out - n0, W * H / 4);

    mode = 1;
    pulse_vsync();
    auto_exp = 0;
    for (int i = 0; i < W / 2; i++) push_exp(12'h222, i, 0);
    for (int i = 0; i < W / 2; i++) push_exp(12'hFFF, i, 1);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (yy == 0)      p = (xx % 2 == 1) ? 12'h222 : 12'h111;
        else if (yy == 1) p = (xx % 2 == 1) ? 12'h555 : 12'h333;
        else              p = 12'hFFF;
        feed(p);
      end
    drain();
    auto_exp = 1;

    feed_rows(2, 0, 1);
    drain();
    mode = 0;
    feed_rows(2, 2, 3);
    drain();
    pulse_vsync();
    feed_rows(1, 0, H - 1);
    drain();

    for (int xx = 0; xx < 5; xx++) feed(gen(1, xx, 0));
    drain();
    pulse_href();
    feed_rows(1, 0, H - 1);
    drain();

    for (int xx = 0; xx < 3; xx++) feed(gen(0, xx, 0));
    drain();
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    chk("mid_rst_valid", int'(scaled_valid), 0);
    chk("mid_rst_data", int'(scaled_data), 0);
    chk("mid_rst_oy", int'(o_y_count), 0);
    chk("mid_rst_rd_en", int'(fifo_rd_en), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    n0 = n_out;
    feed_rows(0, 0, H - 1);
    drain();
    chk("unsynced_count", n_out - n0, 0);
    feed_rows(1, 0, H - 1);
    drain();
    chk("resync_count", n_out - n0, W * H / 4);

    chk("exp_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
